// File: rtl/agc_monitor_responder.sv
// agc_monitor_responder: AGC-side responder for the monitor (MON) interface.
// Generates timepulses MT01..MT12, honours MSTP/MSTRT, latches monitor requests and
// runs the matching unprogrammed sequence against a small erasable and channel model.
// Optional feature: define MON_PARITY_CHECK_EN to enable the odd-parity check on STORE
// data and the sticky PARALM alarm; when undefined PARALM is tied low.
module agc_monitor_responder #(
  parameter int MEM_AW    = 6,
  parameter int TP_LEN    = 1,
  parameter int INST_MCTS = 2
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        MSTRT,
  input  logic        MSTP,
  input  logic [15:0] MDT,
  input  logic        MONPAR,
  input  logic        MREAD,
  input  logic        MLOAD,
  input  logic        MRDCH,
  input  logic        MLDCH,
  input  logic        MTCSAI,
  output logic [11:0] MT,
  output logic [15:0] MWL,
  output logic [2:0]  MST,
  output logic        MREQIN,
  output logic        MNISQ,
  output logic        MWSG,
  output logic        MWG,
  output logic        MWZG,
  output logic        MRGG,
  output logic        MWCH,
  output logic        PARALM
);

  localparam int TPW = (TP_LEN > 1) ? $clog2(TP_LEN) : 1;
  localparam int MCW = (INST_MCTS > 1) ? $clog2(INST_MCTS) : 1;
  localparam logic [TPW-1:0] TP_LAST  = TPW'(TP_LEN - 1);
  localparam logic [MCW-1:0] MCT_LAST = MCW'(INST_MCTS - 1);
  localparam logic [11:0]    Z_RESET  = 12'o4000;

  // Timepulse indices (0 = T01 ... 11 = T12)
  localparam logic [3:0] T01 = 4'd0;
  localparam logic [3:0] T04 = 4'd3;
  localparam logic [3:0] T07 = 4'd6;
  localparam logic [3:0] T08 = 4'd7;
  localparam logic [3:0] T09 = 4'd8;
  localparam logic [3:0] T10 = 4'd9;
  localparam logic [3:0] T12 = 4'd11;

  typedef enum logic [2:0] {
    SEQ_FETCH,
    SEQ_STORE,
    SEQ_INOTRD,
    SEQ_INOTLD,
    SEQ_TCSAJ
  } seq_e;

  // Sequencer state
  logic           fresh_q,  fresh_d;
  logic [3:0]     tp_q,     tp_d;
  logic [TPW-1:0] tp_cnt_q, tp_cnt_d;
  logic [MCW-1:0] mct_q,    mct_d;
  logic           stage_q,  stage_d;
  logic           mreqin_q, mreqin_d;
  seq_e           kind_q,   kind_d;
  logic [11:0]    z_q,      z_d;
  logic [15:0]    bank_q,   bank_d;
  logic [MEM_AW-1:0] addr_q, addr_d;

  // Registered outputs
  logic [11:0] mt_q,    mt_d;
  logic [15:0] mwl_q,   mwl_d;
  logic        mnisq_q, mnisq_d;
  logic        mwsg_q,  mwsg_d;
  logic        mwg_q,   mwg_d;
  logic        mwzg_q,  mwzg_d;
  logic        mrgg_q,  mrgg_d;
  logic        mwch_q,  mwch_d;

  // Erasable and channel model
  logic [15:0] mem  [2**MEM_AW];
  logic [15:0] chan [8];
  logic        mem_we;
  logic        chan_we;

  logic enter;
  logic boundary;

`ifdef MON_PARITY_CHECK_EN
  logic paralm_q, paralm_d;
`else
  logic unused_monpar;
  assign unused_monpar = MONPAR;
`endif

  // Next-state: timepulse advance, request latch, sequence actions and output strobes
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    fresh_d  = 1'b0;
    tp_d     = tp_q;
    tp_cnt_d = tp_cnt_q;
    mct_d    = mct_q;
    stage_d  = stage_q;
    mreqin_d = mreqin_q;
    kind_d   = kind_q;
    z_d      = z_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    mem_we   = 1'b0;
    chan_we  = 1'b0;
    enter    = 1'b0;
    boundary = 1'b0;
    mwl_d    = 16'd0;
    mnisq_d  = 1'b0;
    mwsg_d   = 1'b0;
    mwg_d    = 1'b0;
    mwzg_d   = 1'b0;
    mrgg_d   = 1'b0;
    mwch_d   = 1'b0;
`ifdef MON_PARITY_CHECK_EN
    paralm_d = paralm_q;
`endif

    // Timepulse generator; a fresh start goes straight to T01 without boundary actions
    if (fresh_q) begin
      tp_d     = T01;
      tp_cnt_d = '0;
      enter    = 1'b1;
    end else if (tp_cnt_q != TP_LAST) begin
      tp_cnt_d = tp_cnt_q + 1'b1;
    end else if (tp_q != T12) begin
      tp_d     = tp_q + 4'd1;
      tp_cnt_d = '0;
      enter    = 1'b1;
    end else if (!MSTP) begin
      tp_d     = T01;
      tp_cnt_d = '0;
      enter    = 1'b1;
      boundary = 1'b1;
    end

    // MCT boundary: advance the running sequence, or count idle MCTs and latch a request
    if (boundary) begin
      if (mreqin_q) begin
        if (stage_q || kind_q == SEQ_TCSAJ) begin
          mreqin_d = 1'b0;
          stage_d  = 1'b0;
        end else begin
          stage_d = 1'b1;
        end
      end else begin
        if (mct_q == MCT_LAST) begin
          z_d   = z_q + 12'd1;
          mct_d = '0;
        end else begin
          mct_d = mct_q + 1'b1;
        end
        if (MREAD || MLOAD || MRDCH || MLDCH || MTCSAI) begin
          mreqin_d = 1'b1;
          stage_d  = 1'b0;
          mct_d    = '0;
          if (MREAD)      kind_d = SEQ_FETCH;
          else if (MLOAD) kind_d = SEQ_STORE;
          else if (MRDCH) kind_d = SEQ_INOTRD;
          else if (MLDCH) kind_d = SEQ_INOTLD;
          else            kind_d = SEQ_TCSAJ;
        end
      end
    end

    // One-shot data actions taken on entry to the relevant timepulse
    if (enter && mreqin_d && !stage_d) begin
      if (tp_d == T04) bank_d = MDT;
      if (tp_d == T08) begin
        addr_d = MDT[MEM_AW-1:0];
        if (kind_d == SEQ_TCSAJ) z_d = MDT[11:0];
      end
    end
    if (enter && mreqin_d && stage_d && tp_d == T09) begin
      mem_we  = (kind_d == SEQ_STORE);
      chan_we = (kind_d == SEQ_INOTLD);
    end

`ifdef MON_PARITY_CHECK_EN
    // Odd parity over data plus MONPAR; the word is still written on a mismatch
    if (mem_we && !(^{MDT, MONPAR})) paralm_d = 1'b1;
`endif

    // Outputs for the upcoming cycle, held for every cycle of the timepulse
    mt_d = 12'd1 << tp_d;
    if (!mreqin_d) begin
      if (tp_d == T08) begin
        mwsg_d = 1'b1;
        mwl_d  = {4'd0, z_q};
      end
      if (tp_d == T12 && mct_d == MCT_LAST) mnisq_d = 1'b1;
    end else if (!stage_d) begin
      if (tp_d == T08) begin
        mwsg_d = 1'b1;
        mwl_d  = MDT & 16'o7777;
        mwzg_d = (kind_d == SEQ_TCSAJ);
      end
    end else begin
      case (kind_d)
        SEQ_FETCH: begin
          if (tp_d == T07) begin
            mwg_d = 1'b1;
            mwl_d = mem[addr_q];
          end else if (tp_d == T10) begin
            mwl_d = bank_q;
          end
        end
        SEQ_STORE: begin
          if (tp_d == T09) begin
            mwg_d = 1'b1;
            mwl_d = MDT;
          end
        end
        SEQ_INOTRD: begin
          if (tp_d == T07) begin
            mrgg_d = 1'b1;
            mwl_d  = chan[addr_q[2:0]];
          end
        end
        SEQ_INOTLD: begin
          if (tp_d == T09) begin
            mwch_d = 1'b1;
            mwl_d  = MDT;
          end
        end
        default: ;
      endcase
    end

    // MSTRT behaves like reset except that the erasable and channel model keep their contents
    if (MSTRT) begin
      fresh_d  = 1'b1;
      tp_d     = T12;
      tp_cnt_d = TP_LAST;
      mct_d    = '0;
      stage_d  = 1'b0;
      mreqin_d = 1'b0;
      kind_d   = SEQ_FETCH;
      z_d      = Z_RESET;
      bank_d   = 16'd0;
      addr_d   = '0;
      mem_we   = 1'b0;
      chan_we  = 1'b0;
      mt_d     = 12'd0;
      mwl_d    = 16'd0;
      mnisq_d  = 1'b0;
      mwsg_d   = 1'b0;
      mwg_d    = 1'b0;
      mwzg_d   = 1'b0;
      mrgg_d   = 1'b0;
      mwch_d   = 1'b0;
`ifdef MON_PARITY_CHECK_EN
      paralm_d = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      fresh_q  <= 1'b1;
      tp_q     <= T12;
      tp_cnt_q <= TP_LAST;
      mct_q    <= '0;
      stage_q  <= 1'b0;
      mreqin_q <= 1'b0;
      kind_q   <= SEQ_FETCH;
      z_q      <= Z_RESET;
      bank_q   <= 16'd0;
      addr_q   <= '0;
      mt_q     <= 12'd0;
      mwl_q    <= 16'd0;
      mnisq_q  <= 1'b0;
      mwsg_q   <= 1'b0;
      mwg_q    <= 1'b0;
      mwzg_q   <= 1'b0;
      mrgg_q   <= 1'b0;
      mwch_q   <= 1'b0;
    end else begin
      fresh_q  <= fresh_d;
      tp_q     <= tp_d;
      tp_cnt_q <= tp_cnt_d;
      mct_q    <= mct_d;
      stage_q  <= stage_d;
      mreqin_q <= mreqin_d;
      kind_q   <= kind_d;
      z_q      <= z_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      mt_q     <= mt_d;
      mwl_q    <= mwl_d;
      mnisq_q  <= mnisq_d;
      mwsg_q   <= mwsg_d;
      mwg_q    <= mwg_d;
      mwzg_q   <= mwzg_d;
      mrgg_q   <= mrgg_d;
      mwch_q   <= mwch_d;
    end
  end

  // Erasable and channel writes; a reset cycle writes nothing
  always_ff @(posedge SIM_CLK) begin
    // NOTE: the storage arrays have no reset; their contents survive SIM_RST and MSTRT.
    if (!SIM_RST && mem_we)  mem[addr_q]       <= MDT;
    if (!SIM_RST && chan_we) chan[addr_q[2:0]] <= MDT;
  end

`ifdef MON_PARITY_CHECK_EN
  // Sticky parity alarm, cleared only by reset or MSTRT
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) paralm_q <= 1'b0;
    else         paralm_q <= paralm_d;
  end
  assign PARALM = paralm_q;
`else
  assign PARALM = 1'b0;
`endif

  assign MT     = mt_q;
  assign MWL    = mwl_q;
  assign MST    = {2'b00, stage_q};
  assign MREQIN = mreqin_q;
  assign MNISQ  = mnisq_q;
  assign MWSG   = mwsg_q;
  assign MWG    = mwg_q;
  assign MWZG   = mwzg_q;
  assign MRGG   = mrgg_q;
  assign MWCH   = mwch_q;

endmodule
